// File: rtl/fetch_responder.sv
// fetch_responder: fixed-latency instruction-fetch target with flush and a side load port.
// One fetch is in flight at a time; the response is a single-cycle pulse with no backpressure.
module fetch_responder #(
    parameter int MEM_DEPTH = 1024,
    parameter int LATENCY   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    input  logic [31:0]                  req_addr,
    output logic                         req_ready,
    input  logic                         flush,
    output logic                         resp_valid,
    output logic [31:0]                  resp_inst,
    output logic [31:0]                  resp_addr,
    output logic                         resp_error,
    input  logic                         load_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] load_addr,
    input  logic [31:0]                  load_data
);
    localparam int          AW     = $clog2(MEM_DEPTH);
    localparam logic [4:0]  LAT_M1 = 5'(LATENCY - 1);
    localparam logic [31:0] NOP    = 32'h00000013;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      r_state, w_state_nxt;
    logic [4:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_mem [MEM_DEPTH];
    logic        w_accept, w_err;

    assign req_ready  = (r_state == IDLE || r_state == RESP) && !flush && !reset;
    assign resp_valid = r_state == RESP && !flush;
    assign w_accept   = req_valid && req_ready;
    // Any set bit above the word index places the word beyond the array.
    assign w_err      = req_addr[1:0] != 2'b00 || req_addr[31:AW+2] != '0;

    always_comb begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = r_cnt;
        if (flush)
            w_cnt_nxt = '0;
        else if (w_accept) begin
            w_state_nxt = LAT_M1 == 5'd0 ? RESP : BUSY;
            w_cnt_nxt   = LAT_M1;
        end else if (r_state == BUSY) begin
            w_state_nxt = r_cnt == 5'd1 ? RESP : BUSY;
            w_cnt_nxt   = r_cnt - 5'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_inst  <= '0;
            resp_addr  <= '0;
            resp_error <= 1'b0;
        end else if (w_accept) begin
            resp_inst  <= w_err ? NOP : r_mem[req_addr[2 +: AW]];
            resp_addr  <= req_addr;
            resp_error <= w_err;
        end
    end

    // Backing array keeps its contents across reset and is loadable at any time.
    always_ff @(posedge clk) begin
        if (load_en)
            r_mem[load_addr] <= load_data;
    end
endmodule

// File: tb/tb_fetch_responder.sv
// tb_fetch_responder: directed bench for fetch_responder at LATENCY=4 and LATENCY=1.
// A due-time model of each responder is checked every cycle, plus hand-computed literals.
module tb_fetch_responder;
    logic              clk, reset, flush, load_en;
    logic [9:0]        load_addr;
    logic [31:0]       load_data;
    logic [1:0]        rv, rdy, vld, er;
    logic [1:0][31:0]  ra, inst, addr;

    int tests = 0, fails = 0;
    int cyc = 0;
    int lat [2] = '{4, 1};

    bit          pv  [2];
    int          due [2];
    logic [31:0] pa  [2], pi [2];
    logic        pe  [2];
    logic [31:0] mm  [1024];

    fetch_responder #(.MEM_DEPTH(1024), .LATENCY(4)) u4 (
        .clk(clk), .reset(reset), .req_valid(rv[0]), .req_addr(ra[0]), .req_ready(rdy[0]),
        .flush(flush), .resp_valid(vld[0]), .resp_inst(inst[0]), .resp_addr(addr[0]),
        .resp_error(er[0]), .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );
    fetch_responder #(.MEM_DEPTH(1024), .LATENCY(1)) u1 (
        .clk(clk), .reset(reset), .req_valid(rv[1]), .req_addr(ra[1]), .req_ready(rdy[1]),
        .flush(flush), .resp_valid(vld[1]), .resp_inst(inst[1]), .resp_addr(addr[1]),
        .resp_error(er[1]), .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic f_err(input logic [31:0] a);
        return a[1:0] != 2'b00 || a >= 32'h1000;
    endfunction

    function automatic logic exp_ready(input int k);
        return !reset && !flush && (!pv[k] || due[k] == cyc);
    endfunction

    function automatic logic exp_valid(input int k);
        return !reset && !flush && pv[k] && due[k] == cyc;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    // Model: a fetch is a pending record that answers exactly LATENCY cycles after its accept.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rv[k] && exp_ready(k)) begin
                pv[k]  <= 1'b1;
                due[k] <= cyc + lat[k];
                pa[k]  <= ra[k];
                pe[k]  <= f_err(ra[k]);
                pi[k]  <= f_err(ra[k]) ? 32'h00000013 : mm[ra[k][11:2]];
            end else if (reset || flush || (pv[k] && due[k] == cyc))
                pv[k] <= 1'b0;
        end
        if (load_en)
            mm[load_addr] <= load_data;
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("u%0d_ready", k), 32'(rdy[k]), 32'(exp_ready(k)));
            chk($sformatf("u%0d_valid", k), 32'(vld[k]), 32'(exp_valid(k)));
            if (reset) begin
                chk($sformatf("u%0d_rst_inst", k), inst[k], 32'h0);
                chk($sformatf("u%0d_rst_addr", k), addr[k], 32'h0);
                chk($sformatf("u%0d_rst_err", k), 32'(er[k]), 32'h0);
            end else if (exp_valid(k)) begin
                chk($sformatf("u%0d_inst", k), inst[k], pi[k]);
                chk($sformatf("u%0d_addr", k), addr[k], pa[k]);
                chk($sformatf("u%0d_err", k), 32'(er[k]), 32'(pe[k]));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic at_neg;
        @(negedge clk);
        #1;
    endtask

    task automatic load(input logic [9:0] a, input logic [31:0] d);
        load_en = 1; load_addr = a; load_data = d;
        tick();
        load_en = 0;
    endtask

    initial begin
        reset = 1; flush = 0; load_en = 0; load_addr = '0; load_data = '0;
        rv = '0; ra = '0;
        tick(3);
        reset = 0;
        at_neg;
        chk("ready_after_reset", 32'(rdy[0]), 32'h1);
        load(10'd0, 32'h00500093);
        load(10'd5, 32'hdeadbeef);

        // single fetch, latency 4
        rv[0] = 1; ra[0] = 32'h0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) rv[0] = 0;
            at_neg;
            chk("lat_ready", 32'(rdy[0]), 32'(k == 4));
            chk("lat_valid", 32'(vld[0]), 32'(k == 4));
        end
        chk("lat_inst", inst[0], 32'h00500093);
        chk("lat_addr", addr[0], 32'h0);
        chk("lat_err", 32'(er[0]), 32'h0);
        tick(2);

        // back-to-back with held req_valid
        load(10'd0, 32'd1); load(10'd1, 32'd2); load(10'd2, 32'd3); load(10'd3, 32'd4);
        rv[0] = 1; ra[0] = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick(4);
            if (i == 2) rv[0] = 0; else ra[0] = (i + 1) * 4;
            at_neg;
            chk("b2b_inst", inst[0], i + 1);
        end
        tick();

        // misaligned and out-of-range addresses
        rv[0] = 1; ra[0] = 32'h2;
        tick(); rv[0] = 0; tick(3);
        rv[0] = 1; ra[0] = 32'h1000;
        at_neg;
        chk("misalign_err", 32'(er[0]), 32'h1);
        chk("misalign_inst", inst[0], 32'h00000013);
        tick(); rv[0] = 0; tick(3);
        at_neg;
        chk("oor_err", 32'(er[0]), 32'h1);
        chk("oor_inst", inst[0], 32'h00000013);
        chk("oor_addr", addr[0], 32'h1000);
        tick();

        // flush while busy, then a fresh fetch
        rv[0] = 1; ra[0] = 32'h4;
        tick(); rv[0] = 0; tick();
        flush = 1; tick();
        flush = 0; rv[0] = 1; ra[0] = 32'h8;
        at_neg;
        chk("flush_ready", 32'(rdy[0]), 32'h1);
        tick(); rv[0] = 0;
        at_neg;
        chk("flush_cancel", 32'(vld[0]), 32'h0);
        tick(3);
        at_neg;
        chk("flush_new_valid", 32'(vld[0]), 32'h1);
        chk("flush_new_inst", inst[0], 32'd3);
        tick();

        // flush during the response cycle, then during a presented request
        rv[0] = 1; ra[0] = 32'h0;
        tick(); rv[0] = 0; tick(3);
        flush = 1;
        at_neg;
        chk("flush_resp", 32'(vld[0]), 32'h0);
        tick();
        rv[0] = 1;
        at_neg;
        chk("flush_blocks", 32'(rdy[0]), 32'h0);
        tick(); flush = 0; rv[0] = 0;
        tick(5);

        // read-before-write on the accept edge
        load(10'd6, 32'haaaa0001);
        rv[0] = 1; ra[0] = 32'd24;
        load_en = 1; load_addr = 10'd6; load_data = 32'hbbbb0002;
        tick(); rv[0] = 0; load_en = 0; tick(3);
        at_neg;
        chk("rbw_old", inst[0], 32'haaaa0001);
        tick(); rv[0] = 1; ra[0] = 32'd24;
        tick(); rv[0] = 0; tick(3);
        at_neg;
        chk("rbw_new", inst[0], 32'hbbbb0002);
        tick();

        // asynchronous reset while busy
        rv[0] = 1; ra[0] = 32'h4;
        tick(); rv[0] = 0; tick();
        #2 reset = 1;
        #1;
        chk("arst_valid", 32'(vld[0]), 32'h0);
        chk("arst_ready", 32'(rdy[0]), 32'h0);
        chk("arst_inst", inst[0], 32'h0);
        chk("arst_addr", addr[0], 32'h0);
        tick(); reset = 0;
        at_neg;
        chk("arst_release_ready", 32'(rdy[0]), 32'h1);
        tick(5);
        rv[0] = 1; ra[0] = 32'd20;
        tick(); rv[0] = 0; tick(3);
        at_neg;
        chk("mem_kept_inst", inst[0], 32'hdeadbeef);
        chk("mem_kept_addr", addr[0], 32'd20);
        tick();

        // LATENCY=1 streaming
        rv[1] = 1; ra[1] = 32'h0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i == 4) rv[1] = 0; else ra[1] = i * 4;
            at_neg;
            chk("l1_ready", 32'(rdy[1]), 32'h1);
            chk("l1_valid", 32'(vld[1]), 32'h1);
            chk("l1_inst", inst[1], i);
        end
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_responder.md
# fetch_responder

Instruction-fetch memory responder: the target end of the fetch request the PC stage issues.
- Accepts one word-aligned byte address at a time over a valid/ready handshake.
- Returns the 32-bit instruction after a fixed, parameterised latency, so the core's fetch/stall logic (pc_write) is exercised against a non-ideal memory.
- Supports a pipeline flush that cancels an in-flight fetch.
- Provides a side load port for programming the backing array.

## Interface
Parameters:
- MEM_DEPTH, 1024: number of 32-bit words in the backing array (power of two).
- LATENCY, 4: cycles from request acceptance to response. Legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  fetch request present.
- req_addr  in  32  byte address of instruction.
- req_ready  out  1  responder can accept a request this cycle.
- flush  in  1  cancel any in-flight or presenting fetch.
- resp_valid  out  1  response valid; one-cycle pulse, no backpressure.
- resp_inst  out  32  fetched instruction.
- resp_addr  out  32  byte address the response belongs to.
- resp_error  out  1  address misaligned or out of range.
- load_en  in  1  write enable for the backing array.
- load_addr  in  log2(MEM_DEPTH)  word index to write.
- load_data  in  32  word to write.

## Operation
FSM states:
- IDLE: waiting for a request.
- BUSY: waiting out the latency.
- RESP: response cycle.

Handshake and transitions:
- A request is accepted on a rising edge where req_valid && req_ready && !flush.
- req_ready = (state==IDLE || state==RESP) && !flush && !reset.
- On accept, the 5-bit down-counter loads LATENCY-1.
  - If LATENCY-1 == 0, next state is RESP; otherwise next state is BUSY.
- In BUSY the counter decrements each cycle. When counter==1, next state is RESP and the counter becomes 0.
- RESP lasts exactly one cycle, with resp_valid = (state==RESP) && !flush.
  - If a request is accepted in the RESP cycle, the next state is chosen as on any accept, giving back-to-back operation.
  - Otherwise the next state is IDLE.
- flush high in any cycle forces next state IDLE and blocks acceptance. A fetch in BUSY or RESP produces no response.
- flush has priority over req_valid.

Data path (all captured at the accept edge):
- resp_addr <= req_addr.
- Error check: err = (req_addr[1:0] != 0) || (req_addr[31:2] >= MEM_DEPTH).
- resp_error <= err.
- resp_inst <= 32'h00000013 (RISC-V NOP, addi x0,x0,0) if err, else mem[req_addr[2+:log2(MEM_DEPTH)]].
- The array read is read-before-write. A load_en write to the same word on the accept edge does not affect the captured resp_inst.
- resp_inst, resp_addr and resp_error hold until the next accept. They are meaningful only while resp_valid is high.

Load port:
- mem[load_addr] <= load_data on the rising edge when load_en is high, in any state, including during reset.
- The array is not cleared by reset.

Reset:
- Asynchronous. Immediately forces state IDLE, counter 0, resp_valid 0, resp_inst 0, resp_addr 0, resp_error 0.
- req_ready is 0 while reset is high and 1 on the first cycle after release.
- A fetch in flight at reset assertion is discarded and never responds.

## Timing
- Accept at edge ending cycle T gives resp_valid high in cycle T+LATENCY only.
- req_ready is low in cycles T+1..T+LATENCY-1 and high again in cycle T+LATENCY.
- Maximum throughput is one request per LATENCY cycles; with LATENCY=1 that is one per cycle.
- resp_valid and req_ready depend combinationally on flush and state only. There is no combinational path from req_addr or req_valid to any output.

## Test plan
- Load mem[0]=32'h00500093, then present req_addr=0 with req_valid and accept at cycle 10 (LATENCY=4) -> resp_valid only in cycle 14, with resp_inst=32'h00500093, resp_addr=0, resp_error=0; req_ready low in cycles 11-13.
- Hold req_valid with addresses 0, 4, 8, each advanced on accept, with mem[0..2]=1,2,3 -> accepts at T, T+4, T+8; responses at T+4, T+8, T+12 with data 1, 2, 3 in order.
- req_addr=32'h2, then req_addr=32'h1000 (word 1024, out of range) -> both responses have resp_error=1 and resp_inst=32'h00000013.
- Accept at T, assert flush in T+2 -> no resp_valid at T+4; req_ready=1 in T+3; a new request accepted in T+3 responds at T+7. Also: flush asserted during the RESP cycle -> resp_valid stays 0.
- Assert reset asynchronously while in BUSY -> all outputs go to 0 before the next edge; no response after release. A subsequent fetch returns the previously loaded word, showing the memory is preserved.
- Set LATENCY=1 and issue continuous requests to addresses 0, 4, 8, 12 -> one response per cycle, each one cycle after its accept, with req_ready constantly 1.
